posit_dot_seq: RTL and testbench

Sequencer that runs one shared combinational posit8 (es=0) MAC datapath as a streaming dot-product engine. It takes a vector length on `start`, accepts that many (A,B) operand pairs over a valid/ready stream, and accumulates A*B into an internal accumulator. It then presents the final posit result on a valid/ready output. It sits between an operand-fetch front end and the result sink, replacing free-running per-cycle accumulation with bounded, framed jobs.

---
 rtl/posit_dot_seq.sv | 179 +++++++++++++++++
 tb/tb_posit_dot_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_dot_seq.sv
// Streaming posit8 (es=0) dot-product sequencer: one combinational fused MAC,
// framed by a start/len job, a valid/ready operand stream and a valid/ready result.
module posit_dot_seq #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             clear,
    output logic             busy,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       res_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             nar_flag,
    output logic [LEN_W-1:0] done_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef struct packed {
        logic              sgn;
        logic signed [4:0] k;     // regime value; scale is 2^k
        logic [5:0]        mant;  // 1.fffff
    } dec_t;

    localparam logic [7:0] NAR = 8'h80;

    state_t           state, state_nxt;
    logic [7:0]       acc;
    logic [7:0]       mac_out;
    logic [LEN_W-1:0] remaining;
    logic             xfer;

    function automatic dec_t decode(input logic [7:0] p);
        dec_t       d;
        logic [6:0] body;
        int         m;
        logic       found;
        body  = 7'(p[7] ? -p : p);
        m     = 0;
        found = 1'b0;
        for (int i = 6; i >= 0; i--) begin
            if (!found) begin
                if (body[i] == body[6]) m++;
                else found = 1'b1;
            end
        end
        d.sgn  = p[7];
        d.k    = body[6] ? 5'(m - 1) : -5'(m);
        d.mant = {1'b1, 5'(({body, 7'b0} << (m + 1)) >> 9)};
        return d;
    endfunction

    // Exact fixed point with the LSB at 2^-22, wide enough for any product plus acc.
    function automatic logic signed [39:0] to_fix(input logic sgn, input logic [11:0] mant,
                                                  input int sh);
        logic [39:0] mag;
        mag = 40'(mant) << sh;
        return $signed(sgn ? -mag : mag);
    endfunction

    function automatic logic [7:0] encode(input logic signed [39:0] f);
        logic        sgn;
        logic [38:0] mag;
        logic [38:0] norm;
        logic [47:0] str;
        logic [6:0]  top;
        logic [6:0]  res;
        logic        rnd;
        int          p;
        int          k;
        int          rl;
        sgn = f[39];
        mag = 39'(sgn ? -f : f);
        p   = 0;
        for (int i = 0; i < 39; i++) begin
            if (mag[i]) p = i;
        end
        k    = p - 22;
        norm = mag << (38 - p);
        res  = 7'h00;
        if (mag == '0) begin
            res = 7'h00;
        end else if (k > 6) begin
            res = 7'h7F;
        end else if (k < -6) begin
            res = 7'h01;
        end else begin
            // Bit string = regime, terminator, fraction; rounded once to 7 bits (RNE).
            str = {norm, 9'b0} << 1;
            if (k >= 0) begin
                rl  = k + 2;
                str = str >> rl;
                str = str | (((48'd1 << (k + 1)) - 48'd1) << (47 - k));
            end else begin
                rl  = 1 - k;
                str = str >> rl;
                str = str | (48'd1 << (48 - rl));
            end
            top = str[47:41];
            rnd = str[40] & ((|str[39:0]) | top[0]);
            res = top + 7'(rnd);
        end
        return sgn ? -{1'b0, res} : {1'b0, res};
    endfunction

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        dec_t                da, db, dc;
        logic signed [39:0]  prod_fix, acc_fix;
        da       = decode(in_a);
        db       = decode(in_b);
        dc       = decode(acc);
        prod_fix = '0;
        acc_fix  = '0;
        if (in_a != 8'h00 && in_b != 8'h00)
            prod_fix = to_fix(da.sgn ^ db.sgn, 12'(da.mant) * 12'(db.mant),
                              int'(da.k) + int'(db.k) + 12);
        if (acc != 8'h00)
            acc_fix = to_fix(dc.sgn, 12'(dc.mant), int'(dc.k) + 17);
        if (in_a == NAR || in_b == NAR || acc == NAR)
            mac_out = NAR;
        else
            mac_out = encode(prod_fix + acc_fix);
    end

    assign in_ready  = (state == RUN) && !clear;
    assign xfer      = in_valid && in_ready;
    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign res_data  = acc;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = (len == '0) ? DONE : RUN;
            RUN:     if (xfer && remaining == LEN_W'(1)) state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clear) state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= 8'h00;
            remaining <= '0;
            done_cnt  <= '0;
            nar_flag  <= 1'b0;
        end else if (clear) begin
            acc       <= 8'h00;
            remaining <= '0;
            done_cnt  <= '0;
            nar_flag  <= 1'b0;
        end else if (state == IDLE && start) begin
            acc       <= 8'h00;
            remaining <= len;
            done_cnt  <= '0;
            nar_flag  <= 1'b0;
        end else if (xfer) begin
            acc       <= mac_out;
            remaining <= remaining - LEN_W'(1);
            done_cnt  <= done_cnt + LEN_W'(1);
            if (mac_out == NAR) nar_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_posit_dot_seq.sv
// Directed bench for posit_dot_seq: hand-computed posit8 dot products, stalls,
// backpressure, zero length, NaR, abort and asynchronous reset.
module tb_posit_dot_seq;

    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             clear;
    logic             busy;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       res_data;
    logic             res_valid;
    logic             res_ready;
    logic             nar_flag;
    logic [LEN_W-1:0] done_cnt;

    int vec_cnt  = 0;
    int err_cnt  = 0;
    int xfer_cnt = 0;

    posit_dot_seq #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .clear     (clear),
        .busy      (busy),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .nar_flag  (nar_flag),
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && in_valid && in_ready) xfer_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [LEN_W-1:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    // 1+1+1+1 = 4.0 (0x70), streamed with in_valid held high.
    task automatic run_basic(input string tag);
        int x0;
        int cyc;
        x0 = xfer_cnt;
        start_job(8'd4);
        check({tag, "_busy"}, busy, 1);
        in_a     = 8'h40;
        in_b     = 8'h40;
        in_valid = 1'b1;
        cyc      = 0;
        while (!res_valid && cyc < 20) begin
            tick();
            cyc++;
            if (cyc == 2) check({tag, "_acc2"}, res_data, 8'h60);
            if (cyc == 3) check({tag, "_acc3"}, res_data, 8'h68);
        end
        check({tag, "_latency"}, cyc, 4);
        check({tag, "_res_valid"}, res_valid, 1);
        check({tag, "_res_data"}, res_data, 8'h70);
        check({tag, "_done_cnt"}, done_cnt, 4);
        check({tag, "_in_ready_done"}, in_ready, 0);
        check({tag, "_xfers"}, xfer_cnt - x0, 4);
        in_valid = 1'b0;
        handshake();
        check({tag, "_res_valid_after"}, res_valid, 0);
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_data_hold"}, res_data, 8'h70);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int x0;
        rst       = 1'b1;
        start     = 1'b1;
        len       = 8'd4;
        clear     = 1'b0;
        in_valid  = 1'b1;
        in_a      = 8'h40;
        in_b      = 8'h40;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 8'h00);
        check("rst_done_cnt", done_cnt, 0);
        check("rst_nar", nar_flag, 0);
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        check("idle_busy", busy, 0);
        check("idle_in_ready", in_ready, 0);

        run_basic("basic");

        // 1*1 + (-1)*1 = 0 with a stall between pairs, then result backpressure.
        start_job(8'd2);
        push(8'h40, 8'h40);
        tick();
        check("stall_acc", res_data, 8'h40);
        check("stall_cnt", done_cnt, 1);
        check("stall_busy", busy, 1);
        push(8'hC0, 8'h40);
        check("cancel_valid", res_valid, 1);
        check("cancel_data", res_data, 8'h00);
        check("cancel_cnt", done_cnt, 2);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", res_valid, 1);
            check("bp_data", res_data, 8'h00);
        end
        handshake();
        check("cancel_released", res_valid, 0);

        // Empty job, then NaR propagation.
        start_job(8'd0);
        check("zero_valid", res_valid, 1);
        check("zero_data", res_data, 8'h00);
        check("zero_cnt", done_cnt, 0);
        handshake();
        start_job(8'd3);
        push(8'h80, 8'h40);
        check("nar_first_flag", nar_flag, 1);
        check("nar_first_acc", res_data, 8'h80);
        push(8'h40, 8'h40);
        push(8'h20, 8'h60);
        check("nar_valid", res_valid, 1);
        check("nar_data", res_data, 8'h80);
        check("nar_flag", nar_flag, 1);
        check("nar_cnt", done_cnt, 3);
        start     = 1'b1;
        len       = 8'd2;
        res_ready = 1'b1;
        tick();
        start     = 1'b0;
        res_ready = 1'b0;
        check("done_start_ignored", busy, 0);
        tick();
        check("done_start_still_idle", busy, 0);
        check("nar_hold", nar_flag, 1);

        // Abort mid-job; clear beats start and blocks the pending pair.
        start_job(8'd5);
        x0 = xfer_cnt;
        push(8'h40, 8'h40);
        push(8'h40, 8'h40);
        check("abort_acc", res_data, 8'h60);
        clear    = 1'b1;
        start    = 1'b1;
        len      = 8'd3;
        in_a     = 8'h40;
        in_b     = 8'h40;
        in_valid = 1'b1;
        #1;
        check("abort_in_ready", in_ready, 0);
        tick();
        clear    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_acc0", res_data, 8'h00);
        check("abort_cnt0", done_cnt, 0);
        check("abort_xfers", xfer_cnt - x0, 2);
        tick();
        check("abort_start_ignored", busy, 0);
        start_job(8'd1);
        push(8'h60, 8'h20);
        check("after_abort_valid", res_valid, 1);
        check("after_abort_data", res_data, 8'h40);
        check("after_abort_cnt", done_cnt, 1);
        handshake();

        // Asynchronous reset between clock edges while RUN.
        start_job(8'd4);
        push(8'h40, 8'h40);
        push(8'h40, 8'h40);
        in_a     = 8'h40;
        in_b     = 8'h40;
        in_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_in_ready", in_ready, 0);
        check("arst_data", res_data, 8'h00);
        check("arst_cnt", done_cnt, 0);
        check("arst_valid", res_valid, 0);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        run_basic("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
